// File: rtl/lsu_wb.sv
// Memory-access / writeback stage: issues one bus transaction per load or store,
// aligns and extends load data, and drives the reg_file write port (rd=0 means no write).
`ifndef CPU_REG_WIDTH
`define CPU_REG_WIDTH 32
`endif
`ifndef CPU_REGNO_WIDTH
`define CPU_REGNO_WIDTH 5
`endif

module lsu_wb (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        i_valid,
  input  logic [3:0]                  i_op,
  input  logic [`CPU_REGNO_WIDTH-1:0] i_rd,
  input  logic [`CPU_REG_WIDTH-1:0]   i_addr,
  input  logic [`CPU_REG_WIDTH-1:0]   i_data,
  output logic                        o_busy,
  output logic                        o_addr_err,
  output logic                        o_bus_req,
  output logic                        o_bus_rnw,
  output logic [`CPU_REG_WIDTH-1:0]   o_bus_addr,
  output logic [3:0]                  o_bus_ben,
  output logic [`CPU_REG_WIDTH-1:0]   o_bus_wdata,
  input  logic                        i_bus_ack,
  input  logic [`CPU_REG_WIDTH-1:0]   i_bus_rdata,
  output logic [`CPU_REGNO_WIDTH-1:0] rd,
  output logic [`CPU_REG_WIDTH-1:0]   rd_data
);

  localparam logic [3:0] OP_ALU = 4'd1, OP_LB = 4'd2, OP_LBU = 4'd3, OP_LH = 4'd4,
                         OP_LHU = 4'd5, OP_LW = 4'd6, OP_SB = 4'd7, OP_SH = 4'd8,
                         OP_SW  = 4'd9;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t                        state_q, state_d;
  logic [3:0]                    op_q, op_d;
  logic [`CPU_REGNO_WIDTH-1:0]   lrd_q, lrd_d;
  logic [1:0]                    off_q, off_d;
  logic                          req_q, req_d;
  logic                          rnw_q, rnw_d;
  logic [`CPU_REG_WIDTH-1:0]     baddr_q, baddr_d;
  logic [3:0]                    ben_q, ben_d;
  logic [`CPU_REG_WIDTH-1:0]     wdata_q, wdata_d;
  logic [`CPU_REGNO_WIDTH-1:0]   rd_q, rd_d;
  logic [`CPU_REG_WIDTH-1:0]     rdat_q, rdat_d;
  logic                          aerr_q, aerr_d;

  logic       is_byte, is_half, is_word, is_load, is_mem, misaligned;
  logic [1:0] off_in;
  logic [3:0] ben_in;
  logic [7:0] lbyte;
  logic [15:0] lhalf;
  logic [`CPU_REG_WIDTH-1:0] ldata;

  assign off_in     = i_addr[1:0];
  assign is_byte    = (i_op == OP_LB) || (i_op == OP_LBU) || (i_op == OP_SB);
  assign is_half    = (i_op == OP_LH) || (i_op == OP_LHU) || (i_op == OP_SH);
  assign is_word    = (i_op == OP_LW) || (i_op == OP_SW);
  assign is_load    = (i_op == OP_LB) || (i_op == OP_LBU) || (i_op == OP_LH) ||
                      (i_op == OP_LHU) || (i_op == OP_LW);
  assign is_mem     = is_byte || is_half || is_word;
  assign misaligned = (is_half && off_in[0]) || (is_word && (off_in != 2'b00));

  always_comb begin
    ben_in = 4'b0000;
    if (is_byte)      ben_in = 4'b1000 >> off_in;
    else if (is_half) ben_in = off_in[1] ? 4'b0011 : 4'b1100;
    else if (is_word) ben_in = 4'b1111;
  end

  // Big-endian lane select on the latched offset
  always_comb begin
    case (off_q)
      2'd0:    lbyte = i_bus_rdata[31:24];
      2'd1:    lbyte = i_bus_rdata[23:16];
      2'd2:    lbyte = i_bus_rdata[15:8];
      default: lbyte = i_bus_rdata[7:0];
    endcase
    lhalf = off_q[1] ? i_bus_rdata[15:0] : i_bus_rdata[31:16];
    case (op_q)
      OP_LB:   ldata = {{24{lbyte[7]}}, lbyte};
      OP_LBU:  ldata = {24'd0, lbyte};
      OP_LH:   ldata = {{16{lhalf[15]}}, lhalf};
      OP_LHU:  ldata = {16'd0, lhalf};
      default: ldata = i_bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lrd_d   = lrd_q;
    off_d   = off_q;
    req_d   = req_q;
    rnw_d   = rnw_q;
    baddr_d = baddr_q;
    ben_d   = ben_q;
    wdata_d = wdata_q;
    rd_d    = '0;
    rdat_d  = rdat_q;
    aerr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (i_op == OP_ALU) begin
            rd_d   = i_rd;
            rdat_d = i_data;
          end else if (is_mem) begin
            if (misaligned) begin
              aerr_d = 1'b1;
            end else begin
              state_d = S_BUS;
              req_d   = 1'b1;
              rnw_d   = is_load;
              baddr_d = {i_addr[31:2], 2'b00};
              ben_d   = ben_in;
              op_d    = i_op;
              lrd_d   = i_rd;
              off_d   = off_in;
              if (is_load)      wdata_d = '0;
              else if (is_byte) wdata_d = {4{i_data[7:0]}};
              else if (is_half) wdata_d = {2{i_data[15:0]}};
              else              wdata_d = i_data;
            end
          end
        end
      end
      S_BUS: begin
        if (i_bus_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          ben_d   = 4'b0000;
          if (rnw_q) begin
            rd_d   = lrd_q;
            rdat_d = ldata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      lrd_q   <= '0;
      off_q   <= '0;
      req_q   <= 1'b0;
      rnw_q   <= 1'b0;
      baddr_q <= '0;
      ben_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdat_q  <= '0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lrd_q   <= lrd_d;
      off_q   <= off_d;
      req_q   <= req_d;
      rnw_q   <= rnw_d;
      baddr_q <= baddr_d;
      ben_q   <= ben_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdat_q  <= rdat_d;
      aerr_q  <= aerr_d;
    end
  end

  assign o_busy      = (state_q == S_BUS);
  assign o_addr_err  = aerr_q;
  assign o_bus_req   = req_q;
  assign o_bus_rnw   = rnw_q;
  assign o_bus_addr  = baddr_q;
  assign o_bus_ben   = ben_q;
  assign o_bus_wdata = wdata_q;
  assign rd          = rd_q;
  assign rd_data     = rdat_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: writebacks are predicted into a scoreboard queue and
// checked by a monitor whenever rd is nonzero; bus and timing checked inline.
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_valid;
  logic [3:0]  i_op;
  logic [4:0]  i_rd;
  logic [31:0] i_addr, i_data;
  logic        o_busy, o_addr_err, o_bus_req, o_bus_rnw;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_ben;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic [4:0]  rd;
  logic [31:0] rd_data;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  lsu_wb dut (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_op(i_op), .i_rd(i_rd),
    .i_addr(i_addr), .i_data(i_data), .o_busy(o_busy), .o_addr_err(o_addr_err),
    .o_bus_req(o_bus_req), .o_bus_rnw(o_bus_rnw), .o_bus_addr(o_bus_addr),
    .o_bus_ben(o_bus_ben), .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack),
    .i_bus_rdata(i_bus_rdata), .rd(rd), .rd_data(rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every nonzero rd must match the oldest predicted writeback
  always @(negedge clk) begin
    if (nrst === 1'b1 && rd !== 5'd0) begin
      if (sb.size() == 0) chk("wb_unexpected", {27'd0, rd, rd_data}, 64'd0);
      else chk("wb_scoreboard", {27'd0, rd, rd_data}, {27'd0, sb.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] d);
    i_valid = v; i_op = op; i_rd = r; i_addr = a; i_data = d;
  endtask

  // One aligned load/store with 'waits' request cycles before the ack cycle
  task automatic bus_op(input string tag, input logic [3:0] op, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                        input int waits, input logic [3:0] ben, input logic [31:0] wdata,
                        input logic rnw, input logic [31:0] wb);
    drive(1'b1, op, r, a, d);
    step();
    drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    chk({tag, "_req"}, {31'd0, o_bus_req, o_busy, rd != 5'd0}, {31'd0, 1'b1, 1'b1, 1'b0});
    chk({tag, "_bus"}, {o_bus_addr, o_bus_ben, 3'd0, o_bus_rnw},
        {a & 32'hFFFF_FFFC, ben, 3'd0, rnw});
    if (!rnw) chk({tag, "_wdata"}, {32'd0, o_bus_wdata}, {32'd0, wdata});
    for (int k = 0; k < waits; k++) begin
      step();
      chk({tag, "_hold"}, {o_bus_addr, o_bus_ben, 1'b0, o_busy, o_bus_req, o_bus_rnw},
          {a & 32'hFFFF_FFFC, ben, 1'b0, 1'b1, 1'b1, rnw});
    end
    i_bus_ack = 1'b1; i_bus_rdata = rdata;
    if (rnw && r != 5'd0) sb.push_back({r, wb});
    step();
    i_bus_ack = 1'b0; i_bus_rdata = 32'hDEAD_BEEF;
    chk({tag, "_done"}, {27'd0, o_bus_req, o_busy, o_bus_ben, rd},
        {27'd0, 1'b0, 1'b0, 4'd0, (rnw ? r : 5'd0)});
  endtask

  initial begin
    nrst = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    i_bus_ack = 1'b0; i_bus_rdata = 32'd0;
    #12;
    chk("reset_outs", {o_busy, o_addr_err, o_bus_req, o_bus_rnw, o_bus_ben, rd, o_bus_addr[22:0], 28'd0},
        64'd0);
    chk("reset_data", {o_bus_wdata, rd_data}, 64'd0);
    nrst = 1'b1;
    step();

    // Back-to-back ALU writebacks
    drive(1'b1, 4'd1, 5'd1, 32'd0, 32'h11); sb.push_back({5'd1, 32'h11});
    step(); chk("alu1_rd", {59'd0, rd}, 64'd1);
    drive(1'b1, 4'd1, 5'd2, 32'd0, 32'h22); sb.push_back({5'd2, 32'h22});
    step(); chk("alu2_rd", {59'd0, rd}, 64'd2);
    drive(1'b1, 4'd1, 5'd3, 32'd0, 32'h33); sb.push_back({5'd3, 32'h33});
    step(); chk("alu3_rd", {59'd0, rd}, 64'd3);
    drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    step(); chk("alu_idle_rd", {59'd0, rd}, 64'd0);

    // NOP and undefined ops never write back; stray ack while idle is ignored
    drive(1'b1, 4'd0, 5'd4, 32'd0, 32'h44); i_bus_ack = 1'b1;
    step(); chk("nop_rd", {58'd0, o_busy, rd}, 64'd0);
    drive(1'b1, 4'd12, 5'd5, 32'd0, 32'h55);
    step(); chk("badop_rd", {57'd0, o_bus_req, o_busy, rd}, 64'd0);
    i_bus_ack = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);

    bus_op("lb",  4'd2, 5'd10, 32'h103, 32'd0, 32'h1234_56F0, 3, 4'b0001, 32'd0, 1'b1, 32'hFFFF_FFF0);
    bus_op("lbu", 4'd3, 5'd11, 32'h103, 32'd0, 32'h1234_56F0, 3, 4'b0001, 32'd0, 1'b1, 32'h0000_00F0);
    bus_op("lb1", 4'd2, 5'd12, 32'h101, 32'd0, 32'h1234_56F0, 0, 4'b0100, 32'd0, 1'b1, 32'h0000_0034);
    bus_op("sh",  4'd8, 5'd13, 32'h202, 32'hAAAA_BEEF, 32'd0, 2, 4'b0011, 32'hBEEF_BEEF, 1'b0, 32'd0);
    bus_op("sb",  4'd7, 5'd14, 32'h101, 32'h1234_565A, 32'd0, 1, 4'b0100, 32'h5A5A_5A5A, 1'b0, 32'd0);
    bus_op("sw",  4'd9, 5'd15, 32'h400, 32'hCAFE_1234, 32'd0, 0, 4'b1111, 32'hCAFE_1234, 1'b0, 32'd0);

    // Misaligned word load is dropped with a one-cycle error pulse
    drive(1'b1, 4'd6, 5'd16, 32'h301, 32'd0);
    step(); drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    chk("lw_mis_err", {59'd0, o_addr_err, o_bus_req, o_busy, rd != 5'd0, 1'b0}, {59'd0, 5'b10000});
    step(); chk("lw_mis_pulse", {61'd0, o_addr_err, o_bus_req, o_busy}, 64'd0);
    drive(1'b1, 4'd8, 5'd0, 32'h203, 32'h1);
    step(); drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    chk("sh_mis_err", {62'd0, o_addr_err, o_bus_req}, {62'd0, 2'b10});

    bus_op("lh",  4'd4, 5'd17, 32'h302, 32'd0, 32'h0000_8001, 1, 4'b0011, 32'd0, 1'b1, 32'hFFFF_8001);
    bus_op("lhu", 4'd5, 5'd18, 32'h300, 32'd0, 32'h8001_7FFF, 0, 4'b1100, 32'd0, 1'b1, 32'h0000_8001);
    bus_op("lw0", 4'd6, 5'd0,  32'h304, 32'd0, 32'h7777_7777, 1, 4'b1111, 32'd0, 1'b1, 32'd0);

    // Single-cycle load followed by a held ALU op: consecutive writebacks
    drive(1'b1, 4'd6, 5'd7, 32'h500, 32'd0);
    step();
    chk("lwf_req", {62'd0, o_bus_req, o_busy}, 64'd3);
    drive(1'b1, 4'd1, 5'd8, 32'd0, 32'h99);
    i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFE_F00D; sb.push_back({5'd7, 32'hCAFE_F00D});
    step();
    i_bus_ack = 1'b0;
    chk("lwf_wb", {57'd0, o_bus_req, o_busy, rd}, {57'd0, 2'b00, 5'd7});
    sb.push_back({5'd8, 32'h99});
    step();
    drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    chk("alu_after_lw", {57'd0, o_bus_req, o_busy, rd}, {57'd0, 2'b00, 5'd8});
    step(); chk("after_pair_rd", {59'd0, rd}, 64'd0);

    // Asynchronous reset in the middle of a bus phase
    drive(1'b1, 4'd6, 5'd9, 32'h600, 32'd0);
    step(); drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    chk("rst_pre_req", {63'd0, o_bus_req}, 64'd1);
    #2 nrst = 1'b0;
    #1 chk("rst_async", {57'd0, o_bus_req, o_busy, rd}, 64'd0);
    i_bus_ack = 1'b1; i_bus_rdata = 32'h1111_1111;
    step(); step();
    nrst = 1'b1;
    step();
    i_bus_ack = 1'b0;
    step();
    chk("rst_no_wb", {57'd0, o_bus_req, o_busy, rd}, 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
